// File: rtl/sim_pcie_axis_model.sv
// Behavioural PCIe endpoint stand-in: link-up sequencing, RX AXI-Stream packet source, TX sink with length checking, cfg read table.
// Define SIM_TX_BACKPRESSURE_EN to throttle s_axis_tx_tready one cycle in every BP_PERIOD.
module sim_pcie_axis_model #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_FUNCS      = 2,
  parameter int PKT_BEATS_F0   = 128,
  parameter int PKT_BEATS_F1   = 512,
  parameter int LINKUP_TIMEOUT = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int BP_PERIOD      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    user_lnk_up,
  output logic                    user_enable_comm,
  input  logic [2:0]              cfg_function_number,
  input  logic                    rx_start,
  output logic [DATA_WIDTH-1:0]   m_axis_rx_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_rx_tkeep,
  output logic                    m_axis_rx_tlast,
  output logic                    m_axis_rx_tvalid,
  input  logic                    m_axis_rx_tready,
  output logic                    rx_busy,
  input  logic [DATA_WIDTH-1:0]   s_axis_tx_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tx_tkeep,
  input  logic                    s_axis_tx_tlast,
  input  logic                    s_axis_tx_tvalid,
  output logic                    s_axis_tx_tready,
  output logic [23:0]             tx_beat_count,
  output logic [15:0]             tx_pkt_count,
  output logic                    tx_err,
  input  logic                    cfg_rd_en,
  input  logic [9:0]              cfg_dwaddr,
  output logic [31:0]             cfg_do,
  output logic                    cfg_rd_wr_done
);

  localparam int NumLanes = DATA_WIDTH / 32;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_STREAM,
    RX_GAP
  } rxState_e;

  function automatic logic [31:0] pktSize(input logic [2:0] fn);
    if (int'(fn) >= NUM_FUNCS) return 32'd0;
    case (fn)
      3'd0:    return 32'(PKT_BEATS_F0);
      3'd1:    return 32'(PKT_BEATS_F1);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] laneData(input logic [31:0] base);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int k = 0; k < NumLanes; k++) d[k*32 +: 32] = base + 32'(k);
    return d;
  endfunction

  function automatic logic [31:0] cfgTable(input logic [9:0] addr);
    case (addr)
      10'd4:                      return 32'h0000_0200;
      10'd5:                      return 32'h0000_1000;
      10'd6, 10'd7, 10'd8, 10'd9: return 32'h0000_0000;
      default:                    return 32'hFFFF_FFFF;
    endcase
  endfunction

  logic [31:0] selSize;
  logic        txReady;
  logic        unusedTx;

  assign selSize  = pktSize(cfg_function_number);
  assign unusedTx = ^{s_axis_tx_tdata, s_axis_tx_tkeep};

  logic [31:0] linkCnt_q;
  logic [3:0]  commCnt_q;
  logic        lnkUp_q;
  logic        enableComm_q;

  // user_enable_comm fires once, 15 cycles after the link comes up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      linkCnt_q    <= '0;
      commCnt_q    <= '0;
      lnkUp_q      <= 1'b0;
      enableComm_q <= 1'b0;
    end else begin
      enableComm_q <= 1'b0;
      if (!lnkUp_q) begin
        if (linkCnt_q == 32'(LINKUP_TIMEOUT - 1)) lnkUp_q <= 1'b1;
        else linkCnt_q <= linkCnt_q + 32'd1;
      end else if (commCnt_q != 4'd15) begin
        commCnt_q <= commCnt_q + 4'd1;
        if (commCnt_q == 4'd14) enableComm_q <= 1'b1;
      end
    end
  end

  rxState_e              rxState_q;
  logic [31:0]           rxSize_q;
  logic [31:0]           rxBeat_q;
  logic [31:0]           rxWord_q;
  logic [31:0]           rxGap_q;
  logic                  rxValid_q;
  logic                  rxLast_q;
  logic [DATA_WIDTH-1:0] rxData_q;

  // Size is latched at packet start so later function changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxState_q <= RX_IDLE;
      rxSize_q  <= '0;
      rxBeat_q  <= '0;
      rxWord_q  <= '0;
      rxGap_q   <= '0;
      rxValid_q <= 1'b0;
      rxLast_q  <= 1'b0;
      rxData_q  <= '0;
    end else begin
      case (rxState_q)
        RX_IDLE: begin
          if (rx_start && lnkUp_q && selSize != 32'd0) begin
            rxState_q <= RX_STREAM;
            rxSize_q  <= selSize;
            rxBeat_q  <= '0;
            rxWord_q  <= '0;
            rxValid_q <= 1'b1;
            rxLast_q  <= (selSize == 32'd1);
            rxData_q  <= laneData(32'd0);
          end
        end
        RX_STREAM: begin
          if (m_axis_rx_tready) begin
            if (rxLast_q) begin
              rxState_q <= RX_GAP;
              rxGap_q   <= '0;
              rxValid_q <= 1'b0;
              rxLast_q  <= 1'b0;
              rxData_q  <= '0;
            end else begin
              rxBeat_q <= rxBeat_q + 32'd1;
              rxWord_q <= rxWord_q + 32'(NumLanes);
              rxData_q <= laneData(rxWord_q + 32'(NumLanes));
              rxLast_q <= (rxBeat_q + 32'd2 == rxSize_q);
            end
          end
        end
        RX_GAP: begin
          if (rxGap_q == 32'(GAP_CYCLES - 1)) rxState_q <= RX_IDLE;
          else rxGap_q <= rxGap_q + 32'd1;
        end
        default: rxState_q <= RX_IDLE;
      endcase
    end
  end

`ifdef SIM_TX_BACKPRESSURE_EN
  logic [31:0] bpCnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) bpCnt_q <= '0;
    else if (bpCnt_q == 32'(BP_PERIOD - 1)) bpCnt_q <= '0;
    else bpCnt_q <= bpCnt_q + 32'd1;
  end

  assign txReady = lnkUp_q && (bpCnt_q != 32'(BP_PERIOD - 1));
`else
  assign txReady = lnkUp_q;
`endif

  logic [23:0] txBeatCount_q, txBeatCount_d;
  logic [15:0] txPktCount_q, txPktCount_d;
  logic [31:0] txIdx_q, txIdx_d;
  logic [31:0] txExpLen_q, txExpLen_d;
  logic        txErr_q, txErr_d;
  logic [31:0] txLen;

  // Length check uses the live function on beat 0 and the latched length afterwards.
  always_comb begin
    txBeatCount_d = txBeatCount_q;
    txPktCount_d  = txPktCount_q;
    txIdx_d       = txIdx_q;
    txExpLen_d    = txExpLen_q;
    txErr_d       = txErr_q;
    txLen         = (txIdx_q == 32'd0) ? selSize : txExpLen_q;
    if (s_axis_tx_tvalid && txReady) begin
      txBeatCount_d = txBeatCount_q + 24'd1;
      if (txIdx_q == 32'd0) txExpLen_d = selSize;
      if (s_axis_tx_tlast != (txIdx_q == txLen - 32'd1)) txErr_d = 1'b1;
      if (s_axis_tx_tlast) begin
        txPktCount_d = txPktCount_q + 16'd1;
        txIdx_d      = '0;
      end else begin
        txIdx_d = txIdx_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txBeatCount_q <= '0;
      txPktCount_q  <= '0;
      txIdx_q       <= '0;
      txExpLen_q    <= '0;
      txErr_q       <= 1'b0;
    end else begin
      txBeatCount_q <= txBeatCount_d;
      txPktCount_q  <= txPktCount_d;
      txIdx_q       <= txIdx_d;
      txExpLen_q    <= txExpLen_d;
      txErr_q       <= txErr_d;
    end
  end

  logic [31:0] cfgDo_q;
  logic        cfgDone_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfgDo_q   <= '0;
      cfgDone_q <= 1'b0;
    end else begin
      cfgDone_q <= cfg_rd_en;
      if (cfg_rd_en) cfgDo_q <= cfgTable(cfg_dwaddr);
    end
  end

  assign user_lnk_up      = lnkUp_q;
  assign user_enable_comm = enableComm_q;
  assign m_axis_rx_tdata  = rxData_q;
  assign m_axis_rx_tkeep  = '1;
  assign m_axis_rx_tlast  = rxLast_q;
  assign m_axis_rx_tvalid = rxValid_q;
  assign rx_busy          = (rxState_q != RX_IDLE);
  assign s_axis_tx_tready = txReady;
  assign tx_beat_count    = txBeatCount_q;
  assign tx_pkt_count     = txPktCount_q;
  assign tx_err           = txErr_q;
  assign cfg_do           = cfgDo_q;
  assign cfg_rd_wr_done   = cfgDone_q;

endmodule

// File: doc/sim_pcie_axis_model.md
SIM_PCIE_AXIS_MODEL -- requirements
Module: sim_pcie_axis_model

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter NUM_FUNCS, default 2, number of PCIe functions modelled; legal range 1-8.
REQ-003 SHALL have parameter PKT_BEATS_F0, default 128, packet length in beats for function 0.
REQ-004 SHALL have parameter PKT_BEATS_F1, default 512, packet length in beats for function 1; functions 2..7 have length 0.
REQ-005 SHALL have parameter LINKUP_TIMEOUT, default 16, cycles from reset release to link-up.
REQ-006 SHALL have parameter GAP_CYCLES, default 4, idle cycles after each RX packet.
REQ-007 SHALL have parameter BP_PERIOD, default 4, TX backpressure period in cycles.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-009 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-010 SHALL have port user_lnk_up, output, 1 bit: link is up.
REQ-011 SHALL have port user_enable_comm, output, 1 bit: one-cycle pulse when communication is enabled.
REQ-012 SHALL have port cfg_function_number, input, 3 bits: selects the active function.
REQ-013 SHALL have port rx_start, input, 1 bit: request to generate one RX packet.
REQ-014 SHALL have ports m_axis_rx_tdata (output, DATA_WIDTH), m_axis_rx_tkeep (output, DATA_WIDTH/8), m_axis_rx_tlast (output, 1), m_axis_rx_tvalid (output, 1), m_axis_rx_tready (input, 1) and rx_busy (output, 1).
REQ-015 SHALL have ports s_axis_tx_tdata (input, DATA_WIDTH), s_axis_tx_tkeep (input, DATA_WIDTH/8), s_axis_tx_tlast (input, 1), s_axis_tx_tvalid (input, 1) and s_axis_tx_tready (output, 1).
REQ-016 SHALL have ports tx_beat_count (output, 24), tx_pkt_count (output, 16) and tx_err (output, 1, sticky length error).
REQ-017 SHALL have ports cfg_rd_en (input, 1), cfg_dwaddr (input, 10), cfg_do (output, 32) and cfg_rd_wr_done (output, 1).

Function
REQ-018 SHALL assert user_lnk_up after LINKUP_TIMEOUT cycles with rst_n high and hold it high until reset.
REQ-019 SHALL pulse user_enable_comm for exactly one cycle, 15 cycles after user_lnk_up rises.
REQ-020 The RX state machine SHALL have the states IDLE, STREAM and GAP.
REQ-021 In IDLE, when rx_start and user_lnk_up are high and the selected size is greater than 0, the block SHALL latch that size and go to STREAM; a size of 0 or a function number >= NUM_FUNCS SHALL leave it in IDLE.
REQ-022 In STREAM, the block SHALL hold tvalid high; 32-bit lane k SHALL carry the packet word counter plus k; the word counter starts at 0 per packet and advances by DATA_WIDTH/32 per accepted beat.
REQ-023 SHALL keep tdata and tlast stable while tvalid is high and tready is low.
REQ-024 SHALL assert tlast only on beat number latched-size minus 1; when that beat is accepted, the block SHALL go to GAP and drop tvalid in the next cycle.
REQ-025 SHALL return from GAP to IDLE after GAP_CYCLES cycles.
REQ-026 SHALL ignore rx_start outside IDLE.
REQ-027 SHALL ignore changes to cfg_function_number during a packet.
REQ-028 SHALL drive rx_busy high whenever the state is not IDLE.
REQ-029 SHALL drive m_axis_rx_tkeep to all ones.
REQ-030 SHALL drive s_axis_tx_tready high only while user_lnk_up is high, subject to REQ-040.
REQ-031 A TX beat SHALL be accepted when tvalid and tready are both high; each accepted beat SHALL increment tx_beat_count, wrapping at 2^24.
REQ-032 On the first beat of each TX packet, the block SHALL latch the expected length for cfg_function_number.
REQ-033 When tlast is accepted, the block SHALL increment tx_pkt_count (wrapping at 2^16) and reset the per-packet beat index.
REQ-034 SHALL set tx_err if tlast arrives on any beat other than the expected last beat, or if the expected last beat arrives without tlast; tx_err SHALL stay set until reset.
REQ-035 For a cfg read, cfg_rd_en SHALL produce cfg_do and a one-cycle cfg_rd_wr_done on the next cycle.
REQ-036 The cfg read table SHALL be: address 4 gives 0x00000200, address 5 gives 0x00001000, addresses 6-9 give 0, all other addresses give 0xFFFFFFFF.
REQ-037 Back-to-back cfg_rd_en SHALL produce cfg_rd_wr_done on every cycle.

Reset
REQ-038 With rst_n low at a clock edge, the block SHALL clear all counters, set the RX state to IDLE, set tx_err to 0, and drive user_lnk_up, user_enable_comm, tvalid, tlast, tdata, s_axis_tx_tready, cfg_do and cfg_rd_wr_done to 0.
REQ-039 Reset during a packet SHALL abort the packet: tvalid SHALL be low on the next cycle, and no partial count SHALL survive.

Configuration
REQ-040 With SIM_TX_BACKPRESSURE_EN defined, s_axis_tx_tready SHALL be low one cycle in every BP_PERIOD cycles, driven by a free-running counter; without the macro, tready SHALL equal user_lnk_up.

Verification
REQ-041 Release reset -> user_lnk_up rises at cycle 16, and user_enable_comm pulses once at cycle 31.
REQ-042 Function 0, DATA_WIDTH=32, tready always high, rx_start -> 128 beats with data 0..127, tlast only on beat 127, then rx_busy stays high for 4 gap cycles.
REQ-043 DATA_WIDTH=64, function 1, tready toggled every cycle -> 512 accepted beats, beat n = {2n+1, 2n}, and data is stable while stalled.
REQ-044 TX sink, function 0: send 128 beats with tlast on the final beat -> tx_pkt_count=1, tx_err=0; then send a packet with tlast at beat 10 -> tx_err=1.
REQ-045 cfg_rd_en on addresses 4, 5, 6 and 0x3FF on consecutive cycles -> 0x200, 0x1000, 0, 0xFFFFFFFF with done high for 4 cycles.
REQ-046 Assert rst_n low at beat 50 of an RX packet -> tvalid is 0 next cycle; after link-up, a new packet starts with data 0.
